// File: rtl/tcam_match_resolver.sv
// rtl/tcam_match_resolver.sv - turns a captured TCAM match vector into a priority-ordered address stream
module tcam_match_resolver #(
  parameter int number_of_address_lines = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [(1<<number_of_address_lines)-1:0] match_in,
  input  logic                                  match_valid,
  input  logic                                  flush,
  output logic [number_of_address_lines-1:0]    out_addr,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_last,
  output logic [number_of_address_lines:0]      match_count,
  output logic                                  hit,
  output logic                                  miss,
  output logic                                  busy,
  output logic                                  dropped
);

  localparam int N = number_of_address_lines;
  localparam int W = 1 << N;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [W-1:0] pending_q, pending_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N:0]   count_q, count_d;
  logic         hit_q, hit_d;
  logic         miss_q, miss_d;
  logic         dropped_q, dropped_d;
  logic [W-1:0] addr_bit;
  logic [W-1:0] remaining;

  // Lowest set index wins: scan downwards so the last assignment is the smallest index.
  function automatic logic [N-1:0] lowest_idx(input logic [W-1:0] v);
    lowest_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = i[N-1:0];
    end
  endfunction

  function automatic logic [N:0] popcount(input logic [W-1:0] v);
    popcount = '0;
    for (int i = 0; i < W; i++) begin
      popcount = popcount + {{N{1'b0}}, v[i]};
    end
  endfunction

  always_comb begin
    addr_bit         = '0;
    addr_bit[addr_q] = 1'b1;
    remaining        = pending_q & ~addr_bit;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    count_d   = count_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    dropped_d = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      pending_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (match_valid) begin
            pending_d = match_in;
            count_d   = popcount(match_in);
            if (match_in != '0) begin
              hit_d   = 1'b1;
              addr_d  = lowest_idx(match_in);
              state_d = EMIT;
            end else begin
              miss_d = 1'b1;
            end
          end
        end
        default: begin
          dropped_d = match_valid;
          if (out_ready) begin
            pending_d = remaining;
            if (remaining != '0) begin
              addr_d = lowest_idx(remaining);
            end else begin
              state_d = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      dropped_q <= dropped_d;
    end
  end

  // Valid is implied by the EMIT state, so nothing on out_ready reaches it combinationally.
  assign busy        = (state_q == EMIT);
  assign out_valid   = busy;
  assign out_addr    = addr_q;
  assign out_last    = busy && (pending_q != '0) && ((pending_q & (pending_q - 1'b1)) == '0);
  assign match_count = count_q;
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_tcam_match_resolver.sv
// tb/tb_tcam_match_resolver.sv - self-checking bench for tcam_match_resolver
module tb_tcam_match_resolver;
  localparam int N = 3;
  localparam int W = 1 << N;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] match_in;
  logic         match_valid;
  logic         flush;
  logic         out_ready;
  logic [N-1:0] out_addr;
  logic         out_valid;
  logic         out_last;
  logic [N:0]   match_count;
  logic         hit;
  logic         miss;
  logic         busy;
  logic         dropped;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tcam_match_resolver #(.number_of_address_lines(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .match_in    (match_in),
    .match_valid (match_valid),
    .flush       (flush),
    .out_addr    (out_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .match_count (match_count),
    .hit         (hit),
    .miss        (miss),
    .busy        (busy),
    .dropped     (dropped)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out_addr"}, 32'(out_addr), 0);
    check({tag, " out_valid"}, 32'(out_valid), 0);
    check({tag, " out_last"}, 32'(out_last), 0);
    check({tag, " match_count"}, 32'(match_count), 0);
    check({tag, " hit"}, 32'(hit), 0);
    check({tag, " miss"}, 32'(miss), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " dropped"}, 32'(dropped), 0);
  endtask

  // Reference: the matching addresses are simply the set bits, in ascending order.
  task automatic walk(input logic [W-1:0] vec, input bit rnd, input string tag);
    int q[$];
    int guard;
    for (int i = 0; i < W; i++) if (vec[i]) q.push_back(i);
    match_in    = vec;
    match_valid = 1'b1;
    out_ready   = 1'b0;
    step();
    match_valid = 1'b0;
    check({tag, " hit"}, 32'(hit), 32'(q.size() != 0));
    check({tag, " miss"}, 32'(miss), 32'(q.size() == 0));
    check({tag, " count"}, 32'(match_count), 32'(q.size()));
    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      check({tag, " valid"}, 32'(out_valid), 1);
      check({tag, " addr"}, 32'(out_addr), 32'(q[0]));
      check({tag, " last"}, 32'(out_last), 32'(q.size() == 1));
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (out_ready) void'(q.pop_front());
      if (q.size() > 0) begin
        check({tag, " no hit"}, 32'(hit), 0);
      end
      guard++;
    end
    check({tag, " budget"}, 32'(guard < 200), 1);
    out_ready = 1'b0;
    check({tag, " end valid"}, 32'(out_valid), 0);
    check({tag, " end busy"}, 32'(busy), 0);
    check({tag, " end count"}, 32'(match_count), 32'($countones(vec)));
  endtask

  initial begin
    reset       = 1'b1;
    match_in    = '0;
    match_valid = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    walk(8'b0000_0000, 1'b0, "idle_miss");
    step();
    check("miss pulse ends", 32'(miss), 0);

    walk(8'b1010_0100, 1'b0, "multi");

    // Backpressure on the first address
    match_in = 8'b0001_0010; match_valid = 1'b1;
    step();
    match_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall valid", 32'(out_valid), 1);
      check("stall addr", 32'(out_addr), 1);
      check("stall last", 32'(out_last), 0);
      step();
    end
    out_ready = 1'b1;
    check("bp addr1", 32'(out_addr), 1);
    step();
    check("bp addr4", 32'(out_addr), 4);
    check("bp last4", 32'(out_last), 1);
    step();
    check("bp done", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Capture attempt while a walk is in progress
    match_in = 8'b1100_0000; match_valid = 1'b1;
    step();
    check("drop addr6", 32'(out_addr), 6);
    match_in = 8'b0000_0001;
    step();
    match_valid = 1'b0;
    check("dropped pulse", 32'(dropped), 1);
    check("drop hold addr", 32'(out_addr), 6);
    check("drop count", 32'(match_count), 2);
    out_ready = 1'b1;
    step();
    check("dropped clears", 32'(dropped), 0);
    check("drop addr7", 32'(out_addr), 7);
    check("drop last7", 32'(out_last), 1);
    step();
    check("drop done valid", 32'(out_valid), 0);
    check("drop done busy", 32'(busy), 0);
    out_ready = 1'b0;

    // Flush after address 2 has been accepted
    match_in = 8'hFF; match_valid = 1'b1;
    step();
    match_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("flush pre addr", 32'(out_addr), 32'(i));
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    check("flush valid", 32'(out_valid), 0);
    check("flush busy", 32'(busy), 0);
    check("flush count", 32'(match_count), 8);
    check("flush hit", 32'(hit), 0);
    check("flush miss", 32'(miss), 0);
    check("flush last", 32'(out_last), 0);

    // Flush beats a capture in IDLE
    match_in = 8'h0F; match_valid = 1'b1; flush = 1'b1;
    step();
    match_valid = 1'b0; flush = 1'b0;
    check("flush+mv busy", 32'(busy), 0);
    check("flush+mv hit", 32'(hit), 0);
    check("flush+mv count", 32'(match_count), 8);

    // Asynchronous reset in the middle of a walk
    match_in = 8'hFF; match_valid = 1'b1;
    step();
    match_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("pre-reset addr", 32'(out_addr), 2);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async reset");
    step();
    reset = 1'b0;
    out_ready = 1'b0;
    step();
    check_all_zero("after reset");

    walk(8'hFF, 1'b0, "full");

    for (int k = 0; k < 20; k++) begin
      walk(W'($urandom), 1'b1, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
